// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 datapath boundary blocks.
package sha256_pkg;

    localparam int SHA256_DIGEST_W  = 256;
    localparam int SHA256_BEAT_W    = 64;
    localparam int SHA256_NUM_BEATS = SHA256_DIGEST_W / SHA256_BEAT_W;
    localparam int SHA256_CNT_W     = $clog2(SHA256_NUM_BEATS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/sha256_digest_serializer.sv
// Captures a finished digest in one cycle and streams it out as BEAT_W-bit
// beats over a valid/ready handshake, flagging the final beat.
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int DIGEST_W  = SHA256_DIGEST_W,
    parameter int BEAT_W    = SHA256_BEAT_W,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                digest_valid_i,
    input  logic [DIGEST_W-1:0] digest_i,
    output logic                digest_ready_o,
    output logic [BEAT_W-1:0]   data_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                data_last_o,
    output logic                busy_o
);

    localparam int NUM_BEATS = DIGEST_W / BEAT_W;
    localparam int CNT_W     = $clog2(NUM_BEATS);

    if (((DIGEST_W % BEAT_W) != 0) || (NUM_BEATS < 2)) begin : g_bad_geometry
        $error("sha256_digest_serializer: DIGEST_W must be a multiple of BEAT_W with at least two beats");
    end

    // Advance the buffer by one beat toward the output end, zero filling behind.
    function automatic logic [DIGEST_W-1:0] shift_beat(input logic [DIGEST_W-1:0] b);
        if (MSW_FIRST)
            return b << BEAT_W;
        else
            return b >> BEAT_W;
    endfunction

    function automatic logic [BEAT_W-1:0] head_beat(input logic [DIGEST_W-1:0] b);
        if (MSW_FIRST)
            return b[DIGEST_W-1 -: BEAT_W];
        else
            return b[BEAT_W-1:0];
    endfunction

    ser_state_e          state_p0;
    logic [DIGEST_W-1:0] buf_p0;
    logic [CNT_W-1:0]    cnt_p0;
    logic                vld_p0;
    logic                last_p0;
    logic                rdy_p0;

    logic capture;
    logic beat_xfer;

    // Capture requires the registered ready so nothing is taken while ready is still low after reset.
    assign capture   = (state_p0 == IDLE) && rdy_p0 && digest_valid_i;
    assign beat_xfer = (state_p0 == SEND) && vld_p0 && data_ready_i;

    // Stage p0: capture buffer, beat counter and handshake state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_p0 <= IDLE;
            buf_p0   <= '0;
            cnt_p0   <= '0;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
            rdy_p0   <= 1'b0;
        end else begin
            case (state_p0)
                IDLE: begin
                    rdy_p0  <= 1'b1;
                    vld_p0  <= 1'b0;
                    last_p0 <= 1'b0;
                    if (capture) begin
                        buf_p0   <= digest_i;
                        cnt_p0   <= '0;
                        rdy_p0   <= 1'b0;
                        vld_p0   <= 1'b1;
                        last_p0  <= 1'b0;
                        state_p0 <= SEND;
                    end
                end
                SEND: begin
                    if (beat_xfer) begin
                        buf_p0 <= shift_beat(buf_p0);
                        if (last_p0) begin
                            state_p0 <= IDLE;
                            vld_p0   <= 1'b0;
                            last_p0  <= 1'b0;
                            rdy_p0   <= 1'b1;
                        end else begin
                            cnt_p0  <= cnt_p0 + CNT_W'(1);
                            last_p0 <= (cnt_p0 == CNT_W'(NUM_BEATS - 2));
                        end
                    end
                end
                default: begin
                    state_p0 <= IDLE;
                end
            endcase
        end
    end

    assign data_o         = head_beat(buf_p0);
    assign data_valid_o   = vld_p0;
    assign data_last_o    = last_p0;
    assign busy_o         = vld_p0;
    assign digest_ready_o = rdy_p0;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Bench for sha256_digest_serializer: MSW-first and LSW-first builds run in
// lockstep against a beat-list model derived directly from the digest.
module tb_sha256_digest_serializer;

    localparam int DW = 256;
    localparam int BW = 64;
    localparam int NB = DW / BW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          digest_valid_i;
    logic [DW-1:0] digest_i;
    logic          data_ready_i;

    logic          m_rdy, m_vld, m_last, m_busy;
    logic [BW-1:0] m_data;
    logic          l_rdy, l_vld, l_last, l_busy;
    logic [BW-1:0] l_data;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sha256_digest_serializer #(.DIGEST_W(DW), .BEAT_W(BW), .MSW_FIRST(1'b1)) dut_msw (
        .CLK(CLK), .RST(RST),
        .digest_valid_i(digest_valid_i), .digest_i(digest_i), .digest_ready_o(m_rdy),
        .data_o(m_data), .data_valid_o(m_vld), .data_ready_i(data_ready_i),
        .data_last_o(m_last), .busy_o(m_busy)
    );

    sha256_digest_serializer #(.DIGEST_W(DW), .BEAT_W(BW), .MSW_FIRST(1'b0)) dut_lsw (
        .CLK(CLK), .RST(RST),
        .digest_valid_i(digest_valid_i), .digest_i(digest_i), .digest_ready_o(l_rdy),
        .data_o(l_data), .data_valid_o(l_vld), .data_ready_i(data_ready_i),
        .data_last_o(l_last), .busy_o(l_busy)
    );

    // Model: beat i of the MSW-first stream is the i-th 64-bit word counted from the top.
    function automatic logic [BW-1:0] msw_beat(input logic [DW-1:0] d, input int i);
        return d[DW-1-BW*i -: BW];
    endfunction

    function automatic logic [BW-1:0] lsw_beat(input logic [DW-1:0] d, input int i);
        return d[BW*i +: BW];
    endfunction

    // Streams one digest; stalls stall_n cycles at stall_beat and pulses an
    // all-ones digest during pulse_beat. Starts and ends at a falling edge.
    task automatic stream_frame(input logic [DW-1:0] d, input int stall_beat,
                                input int stall_n, input int pulse_beat, input string tag);
        logic [BW-1:0] em, el;
        logic          elast;
        checks++; if (m_rdy !== 1'b1 || l_rdy !== 1'b1) begin
            errors++; $display("FAIL %s pre_ready got %b/%b want 1", tag, m_rdy, l_rdy); end
        digest_valid_i = 1'b1;
        digest_i       = d;
        data_ready_i   = 1'b1;
        @(negedge CLK);
        digest_valid_i = 1'b0;
        digest_i       = '0;
        for (int b = 0; b < NB; b++) begin
            em    = msw_beat(d, b);
            el    = lsw_beat(d, b);
            elast = (b == NB - 1);
            for (int s = 0; s < ((b == stall_beat) ? stall_n : 0); s++) begin
                data_ready_i = 1'b0;
                checks++; if (m_data !== em || l_data !== el || m_vld !== 1'b1 || l_vld !== 1'b1) begin
                    errors++; $display("FAIL %s stall_beat%0d got %h/%h v%b%b want %h/%h v11",
                                       tag, b, m_data, l_data, m_vld, l_vld, em, el); end
                checks++; if (m_last !== elast || l_last !== elast) begin
                    errors++; $display("FAIL %s stall_last%0d got %b/%b want %b", tag, b, m_last, l_last, elast); end
                @(negedge CLK);
            end
            data_ready_i = 1'b1;
            if (b == pulse_beat) begin
                digest_valid_i = 1'b1;
                digest_i       = '1;
            end
            checks++; if (m_data !== em || l_data !== el) begin
                errors++; $display("FAIL %s beat%0d got %h/%h want %h/%h", tag, b, m_data, l_data, em, el); end
            checks++; if (m_vld !== 1'b1 || l_vld !== 1'b1 || m_busy !== 1'b1 || l_busy !== 1'b1) begin
                errors++; $display("FAIL %s valid_busy%0d got %b%b%b%b want 1111", tag, b, m_vld, l_vld, m_busy, l_busy); end
            checks++; if (m_last !== elast || l_last !== elast) begin
                errors++; $display("FAIL %s last%0d got %b/%b want %b", tag, b, m_last, l_last, elast); end
            checks++; if (m_rdy !== 1'b0 || l_rdy !== 1'b0) begin
                errors++; $display("FAIL %s ready_busy%0d got %b/%b want 0", tag, b, m_rdy, l_rdy); end
            @(negedge CLK);
            digest_valid_i = 1'b0;
            digest_i       = '0;
        end
        checks++; if (m_rdy !== 1'b1 || l_rdy !== 1'b1 || m_vld !== 1'b0 || l_vld !== 1'b0) begin
            errors++; $display("FAIL %s post_idle got rdy%b%b vld%b%b want rdy11 vld00", tag, m_rdy, l_rdy, m_vld, l_vld); end
        checks++; if (m_last !== 1'b0 || l_last !== 1'b0 || m_busy !== 1'b0 || l_busy !== 1'b0) begin
            errors++; $display("FAIL %s post_flags got last%b%b busy%b%b want 0", tag, m_last, l_last, m_busy, l_busy); end
    endtask

    task automatic test_reset();
        RST = 1'b1; digest_valid_i = 1'b0; digest_i = '0; data_ready_i = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if ({m_rdy, m_vld, m_last, m_busy, l_rdy, l_vld, l_last, l_busy} !== 8'h00) begin
            errors++; $display("FAIL reset_flags got %b%b%b%b%b%b%b%b want 0", m_rdy, m_vld, m_last, m_busy, l_rdy, l_vld, l_last, l_busy); end
        checks++; if (m_data !== '0 || l_data !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0", m_data, l_data); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (m_rdy !== 1'b1 || l_rdy !== 1'b1 || m_vld !== 1'b0 || l_vld !== 1'b0) begin
            errors++; $display("FAIL release got rdy%b%b vld%b%b want rdy11 vld00", m_rdy, l_rdy, m_vld, l_vld); end
        // Asynchronous assertion away from any rising edge.
        #2 RST = 1'b1;
        #1;
        checks++; if (m_rdy !== 1'b0 || l_rdy !== 1'b0) begin
            errors++; $display("FAIL async_reset got rdy %b/%b want 0", m_rdy, l_rdy); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic(input logic [DW-1:0] d);
        stream_frame(d, -1, 0, -1, "basic");
    endtask

    task automatic test_backpressure(input logic [DW-1:0] d);
        stream_frame(d, 1, 3, -1, "backpressure");
    endtask

    task automatic test_ignored_input(input logic [DW-1:0] d);
        stream_frame(d, -1, 0, 2, "ignored");
        @(negedge CLK);
        checks++; if (m_vld !== 1'b0 || l_vld !== 1'b0) begin
            errors++; $display("FAIL no_extra_frame got vld %b/%b want 0", m_vld, l_vld); end
    endtask

    task automatic test_reset_midframe(input logic [DW-1:0] d);
        digest_valid_i = 1'b1; digest_i = d; data_ready_i = 1'b1;
        @(negedge CLK);
        digest_valid_i = 1'b0; digest_i = '0;
        repeat (2) @(negedge CLK);
        checks++; if (m_data !== msw_beat(d, 2) || l_data !== lsw_beat(d, 2)) begin
            errors++; $display("FAIL mid_beat3 got %h/%h want %h/%h", m_data, l_data, msw_beat(d, 2), lsw_beat(d, 2)); end
        #2 RST = 1'b1;
        #1;
        checks++; if ({m_rdy, m_vld, m_last, m_busy, l_rdy, l_vld, l_last, l_busy} !== 8'h00
                      || m_data !== '0 || l_data !== '0) begin
            errors++; $display("FAIL mid_reset got vld%b%b data %h/%h want 0", m_vld, l_vld, m_data, l_data); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        stream_frame(d, -1, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int            gap;
        for (int f = 0; f < 8; f++) begin
            for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
            stream_frame(d, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, NB)), "random");
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                data_ready_i = 1'($urandom_range(0, 1));
                @(negedge CLK);
                checks++; if (m_vld !== 1'b0 || l_vld !== 1'b0 || m_rdy !== 1'b1) begin
                    errors++; $display("FAIL idle_gap got vld%b%b rdy%b want vld00 rdy1", m_vld, l_vld, m_rdy); end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] ref_d;
        ref_d = 256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210;
        test_reset();
        test_basic(ref_d);
        test_backpressure(ref_d);
        test_ignored_input(ref_d);
        test_reset_midframe(ref_d);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
